// File: rtl/serial_deser_if.sv
// Receive-side word handshake of serial_deser: the word, its valid/ready pair
// and the two one-cycle status flags.
interface serial_deser_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              frame_err;
    logic              overrun;

    modport master (
        output dout,
        output dout_valid,
        output frame_err,
        output overrun,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  frame_err,
        input  overrun,
        output dout_ready
    );
endinterface

// File: rtl/serial_deser.sv
// Asynchronous-serial style receiver: start bit, DATA_W data bits LSB first,
// stop bit, each CLKS_PER_BIT clocks long, into a one-word holding register.
module serial_deser #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           sin,
    serial_deser_if.master rx
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && rx.dout_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!sin) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Mid-start-bit re-sample rejects glitches shorter than HALF clocks.
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = sin ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    shift_d[idx_q] = sin;
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    // A transfer on this same edge frees the register for the new word.
                    if (!sin) begin
                        ferr_d = 1'b1;
                    end else if (!valid_q || rx.dout_ready) begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx.dout       = dout_q;
    assign rx.dout_valid = valid_q;
    assign rx.frame_err  = ferr_q;
    assign rx.overrun    = ovr_q;

endmodule

// File: tb/tb_serial_deser.sv
// Testbench for serial_deser: directed frames plus random frames, checked every
// cycle against a frame-level model of the holding register and flags.
module tb_serial_deser;

    localparam int DATA_W    = 8;
    localparam int CPB       = 4;
    localparam int HALF      = CPB / 2;
    localparam int FRAME_LEN = (DATA_W + 2) * CPB;
    localparam int ES_OFF    = HALF + (DATA_W + 1) * CPB;

    logic clk;
    logic reset_n;
    logic sin;

    serial_deser_if #(.DATA_W(DATA_W)) rx_if ();

    serial_deser #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sin     (sin),
        .rx      (rx_if.master)
    );

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_dout;
    logic              exp_valid;
    logic              exp_ferr;
    logic              exp_ovr;
    bit                rand_ready;

    logic [DATA_W-1:0] model_acc[$];
    logic [DATA_W-1:0] dut_acc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Words actually taken by the consumer, as seen on the DUT's handshake.
    always @(posedge clk) begin
        if (reset_n && rx_if.dout_valid && rx_if.dout_ready) begin
            dut_acc.push_back(rx_if.dout);
        end
    end

    function automatic logic line_bit(input logic [DATA_W-1:0] word, input logic stop, input int i);
        int slot;
        slot = i / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DATA_W) return word[slot-1];
        return stop;
    endfunction

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic checkOutput();
        check1("dout_valid", 32'(rx_if.dout_valid), 32'(exp_valid));
        check1("dout", 32'(rx_if.dout), 32'(exp_dout));
        check1("frame_err", 32'(rx_if.frame_err), 32'(exp_ferr));
        check1("overrun", 32'(rx_if.overrun), 32'(exp_ovr));
    endtask

    // One clock: the model applies the handshake and frame-end rules, then both are compared.
    task automatic tick(input bit es, input logic stop, input logic [DATA_W-1:0] word);
        bit was_valid;
        bit xfer;
        if (rand_ready) rx_if.dout_ready = 1'($urandom_range(0, 1));
        was_valid = exp_valid;
        xfer      = was_valid && rx_if.dout_ready && reset_n;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        if (xfer) begin
            model_acc.push_back(exp_dout);
            exp_valid = 1'b0;
        end
        if (es && reset_n) begin
            if (!stop) exp_ferr = 1'b1;
            else if (!was_valid || xfer) begin
                exp_dout  = word;
                exp_valid = 1'b1;
            end else exp_ovr = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        for (int k = 0; k < n; k++) tick(1'b0, 1'b1, '0);
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] word, input logic stop, input int gap);
        for (int i = 0; i < FRAME_LEN; i++) begin
            sin = line_bit(word, stop, i);
            tick(i == ES_OFF, stop, word);
        end
        // A zero stop bit stays low past ES, so the line needs time to be rejected as a glitch.
        idle(stop ? gap : gap + CPB + 2);
    endtask

    task automatic drain();
        rx_if.dout_ready = 1'b1;
        tick(1'b0, 1'b1, '0);
        rx_if.dout_ready = 1'b0;
        idle(1);
    endtask

    task automatic compareAccepted(input string tag);
        check1({tag, "_count"}, 32'(dut_acc.size()), 32'(model_acc.size()));
        for (int k = 0; k < model_acc.size() && k < dut_acc.size(); k++) begin
            check1({tag, "_word"}, 32'(dut_acc[k]), 32'(model_acc[k]));
        end
        dut_acc.delete();
        model_acc.delete();
    endtask

    initial begin
        logic [DATA_W-1:0] w;
        logic              st;
        rand_ready       = 1'b0;
        sin              = 1'b1;
        rx_if.dout_ready = 1'b0;
        reset_n          = 1'b0;
        exp_dout         = '0;
        exp_valid        = 1'b0;
        exp_ferr         = 1'b0;
        exp_ovr          = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput();
        reset_n = 1'b1;
        idle(3);

        $display("[TB] frame A5, consumer stalled");
        applyStimulus(8'hA5, 1'b1, 3);
        check1("a5_held", 32'(rx_if.dout), 32'h0000_00A5);
        drain();

        $display("[TB] one-clock start glitch, then 3C");
        sin = 1'b0;
        tick(1'b0, 1'b1, '0);
        idle(4);
        applyStimulus(8'h3C, 1'b1, 2);
        drain();

        $display("[TB] frame 0F with bad stop bit");
        applyStimulus(8'h0F, 1'b0, 2);
        check1("ferr_dout_kept", 32'(rx_if.dout), 32'h0000_003C);

        $display("[TB] overrun: 3C then C3 with no consumer");
        applyStimulus(8'h3C, 1'b1, 0);
        applyStimulus(8'hC3, 1'b1, 2);
        check1("ovr_dout_kept", 32'(rx_if.dout), 32'h0000_003C);
        drain();
        dut_acc.delete();
        model_acc.delete();

        $display("[TB] back-to-back 01, FE with consumer always ready");
        rx_if.dout_ready = 1'b1;
        applyStimulus(8'h01, 1'b1, 0);
        applyStimulus(8'hFE, 1'b1, 3);
        rx_if.dout_ready = 1'b0;
        check1("b2b_first", 32'(model_acc.size() > 0 ? model_acc[0] : 8'h00), 32'h0000_0001);
        compareAccepted("b2b");

        $display("[TB] reset during data bits, then 55");
        w = {4'hF, 4'($urandom_range(0, 15))};
        for (int i = 0; i < FRAME_LEN; i++) begin
            sin = line_bit(w, 1'b1, i);
            if (i == 6 * CPB + 1) begin
                reset_n   = 1'b0;
                exp_dout  = '0;
                exp_valid = 1'b0;
                exp_ferr  = 1'b0;
                exp_ovr   = 1'b0;
                #1;
                checkOutput();
                tick(1'b0, 1'b1, '0);
                reset_n = 1'b1;
            end else begin
                tick(1'b0, 1'b1, '0);
            end
        end
        idle(3);
        applyStimulus(8'h55, 1'b1, 2);
        drain();
        dut_acc.delete();
        model_acc.delete();

        $display("[TB] random frames with random consumer");
        rand_ready = 1'b1;
        for (int f = 0; f < 16; f++) begin
            w  = DATA_W'($urandom);
            st = ($urandom_range(0, 5) != 0);
            applyStimulus(w, st, int'($urandom_range(0, 3)));
        end
        rand_ready       = 1'b0;
        rx_if.dout_ready = 1'b1;
        tick(1'b0, 1'b1, '0);
        compareAccepted("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
